// File: rtl/aes_shift_pkg.sv
// Shared types, FSM encoding, mode constants and row-offset table for the
// ShiftRows / InvShiftRows engine.
package aes_shift_pkg;

  localparam int unsigned BW_DEF = 8;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef logic [BW_DEF-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Rijndael row offsets: 256-bit blocks use {0,1,3,4}, narrower ones {0,1,2,3}
  function automatic logic [2:0] row_offset(input int unsigned nb, input logic [1:0] row);
    logic [2:0] off;
    off = {1'b0, row};
    if (nb == 8 && row == 2'd2) off = 3'd3;
    else if (nb == 8 && row == 2'd3) off = 3'd4;
    return off;
  endfunction

endpackage

// File: rtl/mod_row_rotator.sv
// Combinational rotation of one NB-element state row; left for encrypt,
// right for decrypt.
module mod_row_rotator
  import aes_shift_pkg::*;
#(
  parameter int unsigned NB = 4,
  parameter int unsigned BW = 8
) (
  input  logic [NB*BW-1:0] i_row,
  input  logic [2:0]       i_off,
  input  logic             i_dir,
  output logic [NB*BW-1:0] o_row
);

  always_comb begin
    int src;
    src   = 0;
    o_row = '0;
    for (int c = 0; c < int'(NB); c++) begin
      if (i_dir == MODE_DEC) src = (c + int'(NB) - int'(i_off)) % int'(NB);
      else                   src = (c + int'(i_off)) % int'(NB);
      o_row[c*BW +: BW] = i_row[src*BW +: BW];
    end
  end

endmodule

// File: rtl/mod_shiftrows_engine.sv
// ShiftRows / InvShiftRows engine on a 4 x NB state with valid/ready handshakes.
// MOD_SHIFTRORS_PARALLEL_EN: rotate all four rows in a single SHIFT cycle.
//
//   state | meaning
//   IDLE  | waiting for a state, in_ready high
//   SHIFT | rotating rows of the working register
//   DONE  | result presented, held until out_ready
module mod_shiftrows_engine
  import aes_shift_pkg::*;
#(
  parameter int unsigned NB = 4,
  parameter int unsigned BW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [4*NB*BW-1:0] in_state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NB*BW-1:0] out_state,
  output logic              busy
);

  localparam int unsigned ROW_W = NB * BW;
  localparam int unsigned SW    = 4 * ROW_W;

  state_t          r_state, w_state_nxt;
  logic            r_mode;
  logic [SW-1:0]   r_work, w_work_nxt, r_out_state;
  logic            w_accept, w_last;

`ifdef MOD_SHIFTRORS_PARALLEL_EN
  for (genvar g = 0; g < 4; g++) begin : g_rot
    mod_row_rotator #(.NB(NB), .BW(BW)) u_rot (
      .i_row (r_work[g*ROW_W +: ROW_W]),
      .i_off (row_offset(NB, 2'(g))),
      .i_dir (r_mode),
      .o_row (w_work_nxt[g*ROW_W +: ROW_W])
    );
  end

  assign w_last = 1'b1;
`else
  logic [1:0]       r_row;
  logic [ROW_W-1:0] w_row_in, w_row_out;

  always_comb begin
    w_row_in = '0;
    for (int r = 0; r < 4; r++)
      if (r_row == 2'(r)) w_row_in = r_work[r*ROW_W +: ROW_W];
  end

  mod_row_rotator #(.NB(NB), .BW(BW)) u_rot (
    .i_row (w_row_in),
    .i_off (row_offset(NB, r_row)),
    .i_dir (r_mode),
    .o_row (w_row_out)
  );

  always_comb begin
    w_work_nxt = r_work;
    for (int r = 0; r < 4; r++)
      if (r_row == 2'(r)) w_work_nxt[r*ROW_W +: ROW_W] = w_row_out;
  end

  assign w_last = (r_row == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_row <= 2'd0;
    else if (w_accept)           r_row <= 2'd0;
    else if (r_state == SHIFT)   r_row <= r_row + 2'd1;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT:   if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mode      <= MODE_ENC;
      r_work      <= '0;
      r_out_state <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_work <= in_state;
        r_mode <= in_mode;
      end else if (r_state == SHIFT) begin
        r_work <= w_work_nxt;
        // result register loads only on the DONE-entry edge
        if (w_last) r_out_state <= w_work_nxt;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == SHIFT) || (r_state == DONE);
  assign out_state = r_out_state;

endmodule

// File: tb/tb_mod_shiftrows_engine.sv
// Directed bench for mod_shiftrows_engine: NB=4 and NB=8 instances side by side.
module tb_mod_shiftrows_engine;
  import aes_shift_pkg::*;

`ifdef MOD_SHIFTRORS_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif

  localparam logic [127:0] IN4  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] ENC4 = 128'h0E0D0C0F_09080B0A_04070605_03020100;
  localparam logic [127:0] DEC4 = 128'h0C0F0E0D_09080B0A_06050407_03020100;

  localparam logic [255:0] IN8 = {64'h37363534_33323130, 64'h27262524_23222120,
                                  64'h17161514_13121110, 64'h07060504_03020100};
  localparam logic [255:0] ENC8 = {64'h33323130_37363534, 64'h22212027_26252423,
                                   64'h10171615_14131211, 64'h07060504_03020100};

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         iv4 = 1'b0, ir4, im4 = 1'b0, ov4, or4 = 1'b0, busy4;
  logic [127:0] is4 = '0, os4;
  logic         iv8 = 1'b0, ir8, im8 = 1'b0, ov8, or8 = 1'b0, busy8;
  logic [255:0] is8 = '0, os8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mod_shiftrows_engine #(.NB(4), .BW(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_mode(im4),
    .in_state(is4), .out_valid(ov4), .out_ready(or4), .out_state(os4), .busy(busy4)
  );

  mod_shiftrows_engine #(.NB(8), .BW(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_mode(im8),
    .in_state(is8), .out_valid(ov8), .out_ready(or8), .out_state(os8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ov4(output int lat);
    lat = 0;
    while (!ov4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run4(input logic [127:0] st, input logic mode, output logic [127:0] res);
    int lat;
    @(negedge clk);
    check("in_ready4_idle", ir4, 1);
    iv4 = 1'b1; is4 = st; im4 = mode;
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0; is4 = '1; im4 = ~mode;
    wait_ov4(lat);
    check("latency4", lat, LAT);
    check("in_ready4_done", ir4, 0);
    check("busy4_done", busy4, 1);
    res = os4;
  endtask

  task automatic ack4(input logic [127:0] hold);
    @(negedge clk);
    or4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or4 = 1'b0;
    check("ov4_after_ack", ov4, 0);
    check("ir4_after_ack", ir4, 1);
    check("os4_held", os4, hold);
  endtask

  task automatic run8(input logic [255:0] st, input logic mode, output logic [255:0] res);
    int lat;
    @(negedge clk);
    iv8 = 1'b1; is8 = st; im8 = mode;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0; is8 = '0; im8 = ~mode;
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency8", lat, LAT);
    res = os8;
    or8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or8 = 1'b0;
    check("ov8_after_ack", ov8, 0);
  endtask

  initial begin
    logic [127:0] r4;
    logic [255:0] r8;
    int lat;

    repeat (2) @(negedge clk);
    check("rst_in_ready", ir4, 1);
    check("rst_out_valid", ov4, 0);
    check("rst_busy", busy4, 0);
    check("rst_out_state", os4, 0);
    check("rst_in_ready8", ir8, 1);
    rst_n = 1'b1;

    run4(IN4, MODE_ENC, r4);
    check("enc4", r4, ENC4);
    ack4(ENC4);

    run4(ENC4, MODE_DEC, r4);
    check("dec4_roundtrip", r4, IN4);
    ack4(IN4);

    // backpressure with a second request waiting upstream
    run4(IN4, MODE_DEC, r4);
    check("dec4", r4, DEC4);
    iv4 = 1'b1; is4 = ENC4; im4 = MODE_DEC;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", ov4, 1);
      check("bp_out_state", os4, DEC4);
      check("bp_in_ready", ir4, 0);
    end
    or4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or4 = 1'b0;
    check("bp_release_ov", ov4, 0);
    check("bp_release_ir", ir4, 1);
    check("bp_no_early_accept", busy4, 0);
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0;
    check("bp_second_accept", busy4, 1);
    wait_ov4(lat);
    check("bp_second_latency", lat, LAT);
    check("bp_second_result", os4, IN4);
    ack4(IN4);

    // reset while row 2 is in flight
    @(negedge clk);
    iv4 = 1'b1; is4 = IN4; im4 = MODE_ENC;
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", ov4, 0);
    check("midrst_in_ready", ir4, 1);
    check("midrst_busy", busy4, 0);
    check("midrst_out_state", os4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run4(IN4, MODE_DEC, r4);
    check("post_rst_dec4", r4, DEC4);
    ack4(DEC4);

    run8(IN8, MODE_ENC, r8);
    check("enc8", r8, ENC8);
    run8(ENC8, MODE_DEC, r8);
    check("dec8_roundtrip", r8, IN8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mod_shiftrows_engine.md
Name: mod_shiftrows_engine

Overview:
- Sequential ShiftRows / InvShiftRows engine for the AES256 datapath. It operates on a full 4 x NB byte state rather than on a single row.
- Processes one row per clock through one shared row-rotator instance. Rotation offset and direction are selected per row.
- Sits between the SubBytes and MixColumns stages. Uses a valid/ready handshake on input and output, so it can stall against upstream and downstream stages.

Parameters:
- NB, 4, number of state columns (legal values: 4, 6, 8; Rijndael block sizes)
- BW, 8, bits per state element

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream presents a state
- in_ready  out  1  engine can accept a state
- in_mode  in  1  0 = ShiftRows (encrypt, rotate left); 1 = InvShiftRows (decrypt, rotate right)
- in_state  in  4*NB*BW  input state; element [r][c] at bits ((r*NB+c)*BW) +: BW
- out_valid  out  1  result state valid
- out_ready  in  1  downstream accepts the result
- out_state  out  4*NB*BW  shifted state, same layout as in_state
- busy  out  1  high in SHIFT or DONE

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; row counter goes to 0.
  - in_ready=1, out_valid=0, busy=0, out_state=0.
  - Reset mid-operation discards the block in flight. No partial output is ever presented.
- Row offsets, indexed by row 0..3:
  - NB=4 or 6: {0,1,2,3}
  - NB=8: {0,1,3,4}
  - Encrypt: out[r][c] = in[r][(c+off_r) mod NB]
  - Decrypt: out[r][c] = in[r][(c-off_r+NB) mod NB]
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_state into the working register, latch in_mode, set row=0 and go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle, row `row` of the working register is replaced by its rotated version, then row increments.
  - When row==3 is written, go to DONE.
  - Always 4 cycles, including row 0 (offset 0, pass-through write).
- DONE:
  - out_valid=1 and out_state = working register. Both are held stable while out_ready=0.
  - On out_ready=1: out_valid deasserts on the next edge; go to IDLE with in_ready=1.
  - No back-to-back accept in the DONE->IDLE cycle.
- Latency:
  - Capture edge E0, rows written on E1..E4, out_valid high after E4 (4 cycles).
  - Minimum initiation interval is 6 cycles: capture, 4 x SHIFT, DONE with immediate out_ready.
- Changes to in_mode or in_state after capture have no effect on the block in flight.
- in_valid while in SHIFT or DONE is ignored; upstream must hold it.
- Output registers update only in DONE entry. out_state keeps its last value after handshake until the next result.

Optional Feature:
- Macro: MOD_SHIFTRORS_PARALLEL_EN
- Defined:
  - Four rotator instances process all rows in one cycle. SHIFT lasts 1 cycle, so out_valid is high after E1.
  - Handshake and the DONE-state rules are unchanged.
- Undefined: the sequential single-rotator behaviour above, with 4-cycle latency.

Decomposition:
- Package aes_shift_pkg:
  - typedef for state element: logic [BW-1:0]
  - typedef for the FSM enum {IDLE, SHIFT, DONE}
  - function returning the row offset given (NB, row)
  - mode constants MODE_ENC=0, MODE_DEC=1
- Sub-module mod_row_rotator, purely combinational:
  - Inputs: one NB-element row, a 3-bit offset, and direction.
  - Output: the rotated row.
  - Instanced once (four times under the macro).

Test Plan:
- NB=4 encrypt:
  - Stimulus: state bytes 0x00..0x0F row-major (row1 = 04,05,06,07).
  - Required: after 4 cycles out rows = {00,01,02,03}, {05,06,07,04}, {0A,0B,08,09}, {0F,0C,0D,0E}.
- NB=4 decrypt round-trip:
  - Stimulus: feed the encrypt output back with in_mode=1.
  - Required: out_state equals the original 0x00..0x0F state exactly.
- NB=8 encrypt:
  - Stimulus: row3 = 0x30..0x37.
  - Required: out row3 = 34,35,36,37,30,31,32,33 and row2 = 0x23..0x27,0x20..0x22 (offset 3).
- Backpressure:
  - Stimulus: out_ready held 0 for 10 cycles after out_valid.
  - Required: out_valid and out_state stable throughout, in_ready=0, and a second in_valid is not accepted until 1 cycle after the out handshake.
- Reset mid-SHIFT:
  - Stimulus: assert rst_n=0 at row=2.
  - Required: out_valid=0 and in_ready=1 immediately. A new state injected afterward produces the correct result with no residue from the aborted block.
- Parallel build:
  - Stimulus: repeat the first scenario with MOD_SHIFTRORS_PARALLEL_EN defined.
  - Required: identical output with out_valid high 1 cycle after capture.
